// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone classic initiators in this project.
// Imported by wb_cmd_master and any other master that needs the same bus shape.
package wb_master_pkg;

   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_DAT_W = 32;
   localparam int unsigned WB_SEL_W = 4;

   localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hBADB_AD00;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUS  = 1'b1
   } wb_state_e;

endpackage : wb_master_pkg

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone classic initiator: turns user read/write commands into bus
// cycles, returns read data or a timeout error, and keeps transaction/error counts.
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter int unsigned          TIMEOUT  = 255,
   parameter logic [WB_DAT_W-1:0]  ERR_DATA = ERR_DATA_DEFAULT,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,

   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [WB_ADR_W-1:0]  cmd_adr_i,
   input  logic [WB_DAT_W-1:0]  cmd_dat_i,
   input  logic [WB_SEL_W-1:0]  cmd_sel_i,

   output logic                 rsp_valid_o,
   output logic                 rsp_err_o,
   output logic [WB_DAT_W-1:0]  rsp_dat_o,

   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [WB_SEL_W-1:0]  wbm_sel_o,
   output logic [WB_ADR_W-1:0]  wbm_adr_o,
   output logic [WB_DAT_W-1:0]  wbm_dat_o,
   input  logic                 wbm_ack_i,
   input  logic [WB_DAT_W-1:0]  wbm_dat_i,

   output logic [CNT_W-1:0]     txn_count_o,
   output logic [CNT_W-1:0]     err_count_o
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   wb_state_e            state_q,     state_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 cyc_q,       cyc_d;
   logic                 stb_q,       stb_d;
   logic                 we_q,        we_d;
   logic [WB_SEL_W-1:0]  sel_q,       sel_d;
   logic [WB_ADR_W-1:0]  adr_q,       adr_d;
   logic [WB_DAT_W-1:0]  dat_q,       dat_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q,   rsp_err_d;
   logic [WB_DAT_W-1:0]  rsp_dat_q,   rsp_dat_d;
   logic [TMO_W-1:0]     tmo_q,       tmo_d;
   logic [CNT_W-1:0]     txn_cnt_q,   txn_cnt_d;
   logic [CNT_W-1:0]     err_cnt_q,   err_cnt_d;

   // ACK is checked before the timeout so a late ACK on the last allowed cycle still wins.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      tmo_d       = tmo_q;
      txn_cnt_d   = txn_cnt_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               we_d        = cmd_we_i;
               sel_d       = cmd_sel_i;
               adr_d       = cmd_adr_i;
               dat_d       = cmd_dat_i;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               tmo_d       = '0;
               cmd_ready_d = 1'b0;
               state_d     = BUS;
            end
         end

         BUS: begin
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
               txn_cnt_d   = txn_cnt_q + CNT_W'(1);
            end else if (tmo_q == TMO_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = we_q ? '0 : ERR_DATA;
               txn_cnt_d   = txn_cnt_q + CNT_W'(1);
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + CNT_W'(1);
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         tmo_q       <= '0;
         txn_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         tmo_q       <= tmo_d;
         txn_cnt_q   <= txn_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign txn_count_o = txn_cnt_q;
   assign err_count_o = err_cnt_q;

endmodule : wb_cmd_master

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master with TIMEOUT=8; the slave side
// (ACK and read data) is driven by hand from the stimulus sequence.
module tb_wb_cmd_master;

   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CNT_W   = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              cmdValid;
   logic              cmdReady;
   logic              cmdWe;
   logic [31:0]       cmdAdr;
   logic [31:0]       cmdDat;
   logic [3:0]        cmdSel;
   logic              rspValid;
   logic              rspErr;
   logic [31:0]       rspDat;
   logic              wbCyc;
   logic              wbStb;
   logic              wbWe;
   logic [3:0]        wbSel;
   logic [31:0]       wbAdr;
   logic [31:0]       wbDatOut;
   logic              wbAck;
   logic [31:0]       wbDatIn;
   logic [CNT_W-1:0]  txnCount;
   logic [CNT_W-1:0]  errCount;

   int checks   = 0;
   int failures = 0;
   int stbCycles;

   always #5 clock = ~clock;

   wb_cmd_master #(
      .TIMEOUT  (TIMEOUT),
      .ERR_DATA (32'hBADB_AD00),
      .CNT_W    (CNT_W)
   ) dut (
      .wb_clk_i    (clock),
      .wb_rst_i    (reset),
      .cmd_valid_i (cmdValid),
      .cmd_ready_o (cmdReady),
      .cmd_we_i    (cmdWe),
      .cmd_adr_i   (cmdAdr),
      .cmd_dat_i   (cmdDat),
      .cmd_sel_i   (cmdSel),
      .rsp_valid_o (rspValid),
      .rsp_err_o   (rspErr),
      .rsp_dat_o   (rspDat),
      .wbm_cyc_o   (wbCyc),
      .wbm_stb_o   (wbStb),
      .wbm_we_o    (wbWe),
      .wbm_sel_o   (wbSel),
      .wbm_adr_o   (wbAdr),
      .wbm_dat_o   (wbDatOut),
      .wbm_ack_i   (wbAck),
      .wbm_dat_i   (wbDatIn),
      .txn_count_o (txnCount),
      .err_count_o (errCount)
   );

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a command on the user-side request port.
   task automatic applyStimulus(input logic valid, input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel);
      cmdValid = valid;
      cmdWe    = we;
      cmdAdr   = adr;
      cmdDat   = dat;
      cmdSel   = sel;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      reset   = 1'b1;
      wbAck   = 1'b0;
      wbDatIn = 32'h0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      tick();
      reset = 1'b0;

      // Reset state.
      checkOutput("rst_ready", 32'(cmdReady), 32'd1);
      checkOutput("rst_cyc",   32'(wbCyc),    32'd0);
      checkOutput("rst_stb",   32'(wbStb),    32'd0);
      checkOutput("rst_rspv",  32'(rspValid), 32'd0);
      checkOutput("rst_txn",   32'(txnCount), 32'd0);
      checkOutput("rst_err",   32'(errCount), 32'd0);
      checkOutput("rst_adr",   wbAdr,         32'h0);

      // Write to a zero-wait slave.
      applyStimulus(1'b1, 1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("w_cyc",   32'(wbCyc),    32'd1);
      checkOutput("w_stb",   32'(wbStb),    32'd1);
      checkOutput("w_we",    32'(wbWe),     32'd1);
      checkOutput("w_adr",   wbAdr,         32'h3000_0004);
      checkOutput("w_dat",   wbDatOut,      32'h0000_00A5);
      checkOutput("w_sel",   32'(wbSel),    32'hF);
      checkOutput("w_ready", 32'(cmdReady), 32'd0);
      checkOutput("w_rspv_early", 32'(rspValid), 32'd0);
      wbAck = 1'b1;
      wbDatIn = 32'hFFFF_FFFF;
      tick();
      wbAck = 1'b0;
      checkOutput("w_rspv",  32'(rspValid), 32'd1);
      checkOutput("w_rsperr", 32'(rspErr),  32'd0);
      checkOutput("w_rspdat", rspDat,       32'h0);
      checkOutput("w_txn",   32'(txnCount), 32'd1);
      checkOutput("w_cyc_off", 32'(wbCyc),  32'd0);
      checkOutput("w_ready_back", 32'(cmdReady), 32'd1);
      tick();
      checkOutput("w_rspv_pulse", 32'(rspValid), 32'd0);

      // Read with three wait states.
      applyStimulus(1'b1, 1'b0, 32'h3000_0008, 32'h0, 4'hF);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 1; i <= 3; i++) begin
         checkOutput($sformatf("r_stb_c%0d", i), 32'(wbStb), 32'd1);
         tick();
      end
      checkOutput("r_stb_c4", 32'(wbStb), 32'd1);
      checkOutput("r_rspv_none", 32'(rspValid), 32'd0);
      wbAck   = 1'b1;
      wbDatIn = 32'h1234_5678;
      tick();
      wbAck   = 1'b0;
      wbDatIn = 32'h0;
      checkOutput("r_stb_off", 32'(wbStb),   32'd0);
      checkOutput("r_rspv",   32'(rspValid), 32'd1);
      checkOutput("r_rsperr", 32'(rspErr),   32'd0);
      checkOutput("r_rspdat", rspDat,        32'h1234_5678);
      checkOutput("r_txn",    32'(txnCount), 32'd2);
      tick();
      checkOutput("r_rspdat_hold", rspDat, 32'h1234_5678);

      // Read timeout: slave never acknowledges.
      applyStimulus(1'b1, 1'b0, 32'h3000_000C, 32'h0, 4'hF);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      stbCycles = 0;
      for (int i = 0; i < 20 && wbStb === 1'b1; i++) begin
         stbCycles++;
         tick();
      end
      checkOutput("t_stb_cycles", 32'(stbCycles), 32'd8);
      checkOutput("t_rspv",   32'(rspValid), 32'd1);
      checkOutput("t_rsperr", 32'(rspErr),   32'd1);
      checkOutput("t_rspdat", rspDat,        32'hBADB_AD00);
      checkOutput("t_errcnt", 32'(errCount), 32'd1);
      checkOutput("t_txn",    32'(txnCount), 32'd3);
      tick();

      // Back-to-back: cmd_valid stays high through the first transaction.
      applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0011, 4'h3);
      tick();
      checkOutput("b_a_cyc",   32'(wbCyc),    32'd1);
      checkOutput("b_a_adr",   wbAdr,         32'h0000_0010);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hC);
      wbAck = 1'b1;
      tick();
      wbAck = 1'b0;
      checkOutput("b_a_rspv",  32'(rspValid), 32'd1);
      checkOutput("b_gap_cyc", 32'(wbCyc),    32'd0);
      checkOutput("b_gap_ready", 32'(cmdReady), 32'd1);
      checkOutput("b_a_txn",   32'(txnCount), 32'd4);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("b_b_cyc",   32'(wbCyc),    32'd1);
      checkOutput("b_b_we",    32'(wbWe),     32'd0);
      checkOutput("b_b_adr",   wbAdr,         32'h0000_0020);
      checkOutput("b_b_sel",   32'(wbSel),    32'hC);
      checkOutput("b_b_rspv_none", 32'(rspValid), 32'd0);
      wbAck   = 1'b1;
      wbDatIn = 32'hCAFE_F00D;
      tick();
      wbAck   = 1'b0;
      wbDatIn = 32'h0;
      checkOutput("b_b_rspdat", rspDat,        32'hCAFE_F00D);
      checkOutput("b_b_txn",    32'(txnCount), 32'd5);
      tick();

      // Reset asserted during the second strobe cycle.
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      checkOutput("m_stb_c2", 32'(wbStb), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("m_cyc",    32'(wbCyc),    32'd0);
      checkOutput("m_stb",    32'(wbStb),    32'd0);
      checkOutput("m_ready",  32'(cmdReady), 32'd1);
      checkOutput("m_rspv",   32'(rspValid), 32'd0);
      checkOutput("m_txn",    32'(txnCount), 32'd0);
      checkOutput("m_errcnt", 32'(errCount), 32'd0);
      tick();
      checkOutput("m_rspv_after", 32'(rspValid), 32'd0);

      // Spurious ACK while idle.
      wbAck   = 1'b1;
      wbDatIn = 32'h7777_7777;
      tick();
      tick();
      wbAck   = 1'b0;
      checkOutput("s_rspv",  32'(rspValid), 32'd0);
      checkOutput("s_txn",   32'(txnCount), 32'd0);
      checkOutput("s_ready", 32'(cmdReady), 32'd1);

      // ACK arriving on the last allowed strobe cycle beats the timeout.
      applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 1; i < int'(TIMEOUT); i++) begin
         tick();
      end
      checkOutput("c_stb_last", 32'(wbStb), 32'd1);
      wbAck   = 1'b1;
      wbDatIn = 32'h5A5A_0001;
      tick();
      wbAck   = 1'b0;
      wbDatIn = 32'h0;
      checkOutput("c_rspv",   32'(rspValid), 32'd1);
      checkOutput("c_rsperr", 32'(rspErr),   32'd0);
      checkOutput("c_rspdat", rspDat,        32'h5A5A_0001);
      checkOutput("c_errcnt", 32'(errCount), 32'd0);
      checkOutput("c_txn",    32'(txnCount), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wb_cmd_master
